mem_port_arbiter: RTL and testbench

Shares the single-port main data memory between the pipeline's memory stage (primary requester) and a secondary requester such as a loader or debug port. The pipeline normally has priority. A starvation counter forces a secondary grant after a bounded number of lost cycles, and the pipeline is stalled for that cycle. Read data returns one cycle after issue and is steered to whichever requester issued the read.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port data memory between the pipeline's
// memory stage (primary) and a secondary requester (loader / debug port).
//
// The pipeline wins by default. A starvation counter tracks consecutive cycles
// in which the secondary asked and lost. When it reaches STARVE_MAX, the
// secondary is forced through and the pipeline is stalled for that cycle.
// Memory read data returns one cycle after issue and is steered to whichever
// requester issued the read.
//
// Handshake: a requester holds *_req (with we/addr/wdata) until it is served.
// The pipeline is served in any cycle with p_req=1 and p_stall=0. The
// secondary is served in any cycle with s_gnt=1. The memory command is issued
// combinationally in that same cycle. For a read, *_rvalid pulses exactly one
// cycle later with the data on *_rdata.
//
// Optional build macro: MEM_ARB_STATS_EN adds two 16-bit saturating
// statistics counters. Without the macro the stat ports are tied to zero.

module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,

  input  logic        p_req,
  input  logic        p_we,
  input  logic [15:0] p_addr,
  input  logic [15:0] p_wdata,
  output logic        p_stall,
  output logic [15:0] p_rdata,
  output logic        p_rvalid,

  input  logic        s_req,
  input  logic        s_we,
  input  logic [15:0] s_addr,
  input  logic [15:0] s_wdata,
  output logic        s_gnt,
  output logic [15:0] s_rdata,
  output logic        s_rvalid,

  output logic        m_write_en,
  output logic [15:0] m_address,
  output logic [15:0] m_write_data,
  input  logic [15:0] m_data_in,

  output logic [15:0] stat_stall_cnt,
  output logic [15:0] stat_sgnt_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Registered state
  logic [3:0] starve_q, starve_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;

  // Grant decode
  logic       gnt_p;
  logic       gnt_s;
  logic       forced_s;

  // Priority decision: forced secondary, then pipeline, then idle secondary.
  always_comb begin
    gnt_p    = 1'b0;
    gnt_s    = 1'b0;
    forced_s = 1'b0;
    if (rst && !halt_sys) begin
      if (s_req && (starve_q == STARVE_LIM)) begin
        gnt_s    = 1'b1;
        forced_s = 1'b1;
      end else if (p_req) begin
        gnt_p = 1'b1;
      end else if (s_req) begin
        gnt_s = 1'b1;
      end
    end
  end

  // Memory command mux: granted requester drives the port, zeros when idle.
  always_comb begin
    m_write_en   = 1'b0;
    m_address    = 16'h0000;
    m_write_data = 16'h0000;
    if (gnt_p) begin
      m_write_en   = p_we;
      m_address    = p_addr;
      m_write_data = p_wdata;
    end else if (gnt_s) begin
      m_write_en   = s_we;
      m_address    = s_addr;
      m_write_data = s_wdata;
    end
  end

  assign s_gnt   = gnt_s;
  assign p_stall = p_req & ~gnt_p & ~halt_sys & rst;

  // Starvation counter: counts lost secondary cycles, frozen while halted.
  always_comb begin
    starve_d = starve_q;
    if (!halt_sys) begin
      if (s_req && !gnt_s) begin
        if (starve_q != STARVE_LIM) begin
          starve_d = starve_q + 4'd1;
        end
      end else begin
        starve_d = 4'd0;
      end
    end
  end

  // Read tracking: remember that a read went out this cycle and who owns it.
  always_comb begin
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    if (gnt_p && !p_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = 1'b0;
    end else if (gnt_s && !s_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q   <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Read return steering; reset masks a read still in flight.
  assign p_rvalid = rd_pend_q & ~rd_owner_q & rst;
  assign s_rvalid = rd_pend_q &  rd_owner_q & rst;
  assign p_rdata  = p_rvalid ? m_data_in : 16'h0000;
  assign s_rdata  = s_rvalid ? m_data_in : 16'h0000;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] sgnt_cnt_q, sgnt_cnt_d;

  // Saturating event counters; halt produces no stalls or grants, so they hold.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    sgnt_cnt_d  = sgnt_cnt_q;
    if (p_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (s_gnt && (sgnt_cnt_q != 16'hFFFF)) begin
      sgnt_cnt_d = sgnt_cnt_q + 16'd1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 16'd0;
      sgnt_cnt_q  <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      sgnt_cnt_q  <= sgnt_cnt_d;
    end
  end

  assign stat_stall_cnt = rst ? stall_cnt_q : 16'h0000;
  assign stat_sgnt_cnt  = rst ? sgnt_cnt_q  : 16'h0000;
`else
  assign stat_stall_cnt = 16'h0000;
  assign stat_sgnt_cnt  = 16'h0000;
`endif

  // forced_s is kept as a named decode for checker binding.
  logic unused_ok;
  assign unused_ok = forced_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a cycle-level reference model of the
// arbitration rules and an environment memory array.

module tb_mem_port_arbiter;

  localparam int SM = 4;
`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        halt_sys = 1'b0;
  logic        p_req = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = '0, p_wdata = '0;
  logic        s_req = 1'b0, s_we = 1'b0;
  logic [15:0] s_addr = '0, s_wdata = '0;
  logic [15:0] m_data_in = '0;
  logic        p_stall, p_rvalid, s_gnt, s_rvalid, m_write_en;
  logic [15:0] p_rdata, s_rdata, m_address, m_write_data;
  logic [15:0] stat_stall_cnt, stat_sgnt_cnt;

  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .m_write_en(m_write_en), .m_address(m_address),
    .m_write_data(m_write_data), .m_data_in(m_data_in),
    .stat_stall_cnt(stat_stall_cnt), .stat_sgnt_cnt(stat_sgnt_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Environment memory (contents as seen by the model)
  logic [15:0] mem [logic [15:0]];

  // Reference model state
  int          m_starve   = 0;   // consecutive lost secondary cycles
  bit          m_pend     = 0;   // a read went out last cycle
  bit          m_owner    = 0;   // 1 = secondary owns that read
  logic [15:0] m_raddr    = '0;
  int          tot_stall  = 0;
  int          tot_sgnt   = 0;
  logic [15:0] exp_q [$];        // expected read data in flight

  // Observed values of the most recent cycle, for directed checks
  logic        o_stall, o_sgnt, o_we, o_prv, o_srv;
  logic [15:0] o_addr, o_prd, o_srd, o_stc, o_sgc;

  function automatic logic [15:0] mrd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver + model: one clock cycle with the given inputs.
  task automatic cyc(input bit r, input bit h,
                     input bit pr, input bit pw, input logic [15:0] pa, input logic [15:0] pd,
                     input bit sr, input bit sw, input logic [15:0] sa, input logic [15:0] sd);
    bit pg, sg, e_stall, e_prv, e_srv;
    logic [15:0] e_prd, e_srd, e_addr, e_wd, rdat;
    bit e_we;
    rst = r; halt_sys = h;
    p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    s_req = sr; s_we = sw; s_addr = sa; s_wdata = sd;
    // memory returns the data of last cycle's read, junk otherwise
    if (m_pend) begin
      rdat = exp_q.pop_front();
      m_data_in = rdat;
    end else begin
      rdat = 16'h0000;
      m_data_in = 16'($urandom);
    end
    @(negedge clk);
    pg = 0; sg = 0;
    if (r && !h) begin
      if (sr && m_starve == SM) sg = 1;
      else if (pr) pg = 1;
      else if (sr) sg = 1;
    end
    e_we    = pg ? pw : (sg ? sw : 1'b0);
    e_addr  = pg ? pa : (sg ? sa : 16'h0000);
    e_wd    = pg ? pd : (sg ? sd : 16'h0000);
    e_stall = pr && !pg && !h && r;
    e_prv   = r && m_pend && !m_owner;
    e_srv   = r && m_pend && m_owner;
    e_prd   = e_prv ? rdat : 16'h0000;
    e_srd   = e_srv ? rdat : 16'h0000;
    o_stall = p_stall; o_sgnt = s_gnt; o_we = m_write_en; o_addr = m_address;
    o_prv = p_rvalid; o_srv = s_rvalid; o_prd = p_rdata; o_srd = s_rdata;
    o_stc = stat_stall_cnt; o_sgc = stat_sgnt_cnt;
    chk("p_stall", {15'd0, p_stall}, {15'd0, e_stall});
    chk("s_gnt", {15'd0, s_gnt}, {15'd0, sg});
    chk("m_write_en", {15'd0, m_write_en}, {15'd0, e_we});
    chk("m_address", m_address, e_addr);
    chk("m_write_data", m_write_data, e_wd);
    chk("p_rvalid", {15'd0, p_rvalid}, {15'd0, e_prv});
    chk("s_rvalid", {15'd0, s_rvalid}, {15'd0, e_srv});
    chk("p_rdata", p_rdata, e_prd);
    chk("s_rdata", s_rdata, e_srd);
    chk("stat_stall_cnt", stat_stall_cnt, (STATS && r) ? 16'(tot_stall) : 16'h0000);
    chk("stat_sgnt_cnt", stat_sgnt_cnt, (STATS && r) ? 16'(tot_sgnt) : 16'h0000);
    // advance model to the next cycle
    if (!r) begin
      m_starve = 0; m_pend = 0; m_owner = 0;
      tot_stall = 0; tot_sgnt = 0;
      exp_q.delete();
    end else begin
      if (!h) m_starve = (sr && !sg) ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
      m_pend = (pg && !pw) || (sg && !sw);
      if (m_pend) begin
        m_owner = sg;
        m_raddr = pg ? pa : sa;
        exp_q.push_back(mrd(m_raddr));
      end
      if (pg && pw) mem[pa] = pd;
      if (sg && sw) mem[sa] = sd;
      if (e_stall && tot_stall < 65535) tot_stall++;
      if (sg && tot_sgnt < 65535) tot_sgnt++;
    end
    @(posedge clk);
    #1;
  endtask

  logic [9:0] sg_pat, st_pat;
  bit ok_halt;

  initial begin
    mem[16'h0020] = 16'h1234;
    @(posedge clk); #1;

    // Reset held with both requesting: everything zero.
    cyc(0, 0, 1, 0, 16'h0030, 16'h1111, 1, 0, 16'h0040, 16'h2222);
    cyc(0, 0, 1, 0, 16'h0030, 16'h1111, 1, 0, 16'h0040, 16'h2222);
    chk("rst_addr", o_addr, 16'h0000);
    // First cycle after release grants the pipeline.
    cyc(1, 0, 1, 0, 16'h0030, 16'h1111, 1, 0, 16'h0040, 16'h2222);
    chk("rel_p_stall", {15'd0, o_stall}, 16'h0000);
    chk("rel_addr", o_addr, 16'h0030);
    cyc(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);

    // Ten cycles of full contention.
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 1, 0, 16'(16'h0100 + i), 16'h0, 1, 0, 16'(16'h0200 + i), 16'h0);
      sg_pat[i] = o_sgnt;
      st_pat[i] = o_stall;
    end
    chk("contention_sgnt", {6'd0, sg_pat}, {6'd0, 10'b1000010000});
    chk("contention_stall", {6'd0, st_pat}, {6'd0, 10'b1000010000});
    cyc(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    chk("stats_stall", o_stc, STATS ? 16'd2 : 16'd0);
    chk("stats_sgnt", o_sgc, STATS ? 16'd2 : 16'd0);

    // Pipeline write then read back.
    cyc(1, 0, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 16'h0000);
    chk("pw_we", {15'd0, o_we}, 16'h0001);
    chk("pw_stall", {15'd0, o_stall}, 16'h0000);
    cyc(1, 0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    chk("pr_rvalid", {15'd0, o_prv}, 16'h0001);
    chk("pr_rdata", o_prd, 16'hBEEF);
    chk("pr_s_rvalid", {15'd0, o_srv}, 16'h0000);

    // Secondary alone.
    cyc(1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0020, 16'h0000);
    chk("s_alone_gnt", {15'd0, o_sgnt}, 16'h0001);
    cyc(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    chk("s_alone_rvalid", {15'd0, o_srv}, 16'h0001);
    chk("s_alone_rdata", o_srd, 16'h1234);

    // Halt mid-contention with three lost cycles banked.
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 16'h0005, 16'h0, 1, 0, 16'h0006, 16'h0);
    ok_halt = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 1, 16'h0005, 16'h0, 1, 1, 16'h0006, 16'h0);
      if (o_sgnt || o_we || o_stall) ok_halt = 0;
    end
    chk("halt_quiet", {15'd0, ok_halt}, 16'h0001);
    cyc(1, 0, 1, 0, 16'h0005, 16'h0, 1, 0, 16'h0006, 16'h0);
    chk("halt_rel_pipe", {15'd0, o_sgnt}, 16'h0000);
    cyc(1, 0, 1, 0, 16'h0005, 16'h0, 1, 0, 16'h0006, 16'h0);
    chk("halt_rel_forced", {15'd0, o_sgnt}, 16'h0001);
    chk("halt_rel_stall", {15'd0, o_stall}, 16'h0001);

    // Back-to-back reads to different owners, the second landing in halt.
    cyc(1, 0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0000, 16'h0, 1, 0, 16'h0020, 16'h0);
    chk("b2b_prdata", o_prd, 16'hBEEF);
    cyc(1, 1, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0);
    chk("b2b_halt_srdata", o_srd, 16'h1234);

    // Reset while a read is in flight drops it.
    cyc(1, 0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    cyc(0, 0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("rst_mid_read", {15'd0, o_prv}, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("rst_mid_read_after", {15'd0, o_prv}, 16'h0000);

    // Randomized traffic on a small address window.
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom_range(0, 15)), 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
